// File: rtl/i2c_target.sv
`timescale 1ns/1ps
// i2c_target: 7-bit-address I2C target (responder side of the bus).
//
// The SCL/SDA inputs are synchronised and glitch-filtered. START and STOP
// are detected from the filtered lines. On an address match the block ACKs,
// delivers written bytes on rx_valid, and sources read bytes through a
// tx_req / tx_valid handshake. It can hold SCL low while read data is late.
//
// Ports:
//   clk_in, reset          system clock (>= 20x SCL); synchronous active-high reset
//   scl, sda               open-drain bus lines, driven only 1'b0 or 1'bz
//   rx_data, rx_valid      last written byte; one-cycle strobe when it updates
//   tx_req                 one-cycle strobe asking for the next read byte
//   tx_data, tx_valid      read byte, captured while a request is pending
//   start_detected         one-cycle strobe on START / repeated START
//   stop_detected          one-cycle strobe on STOP
//   busy, read_mode        matched transaction in progress; its R/W bit
module i2c_target #(
  parameter logic [6:0]  TARGET_ADDRESS   = 7'h50,
  parameter int unsigned FILTER_DEPTH     = 3,
  parameter bit          CLOCK_STRETCHING = 1'b1
) (
  input  logic       clk_in,
  input  logic       reset,
  inout  wire        scl,
  inout  wire        sda,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       tx_req,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       start_detected,
  output logic       stop_detected,
  output logic       busy,
  output logic       read_mode
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, RX_BYTE, RX_ACK, TX_LOAD, TX_BYTE, TX_ACK, WAIT_STOP
  } state_t;

  // Input path, bit 0 = SCL, bit 1 = SDA.
  logic [1:0] sync1_q, sync2_q, filt_q, filt_d, filt_prev_q;
  logic [3:0] cnt_q [2];
  logic [3:0] cnt_d [2];

  // NOTE: every signal assigned in an always_comb gets a default first, so no latch is inferred.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      filt_d[i] = filt_q[i];
      cnt_d[i]  = 4'd0;
      // Count consecutive disagreeing samples; the count never exceeds
      // FILTER_DEPTH-1 because the line flips (and the count clears) there.
      if (sync2_q[i] != filt_q[i]) begin
        if (cnt_q[i] >= 4'(FILTER_DEPTH - 1)) filt_d[i] = sync2_q[i];
        else                                  cnt_d[i]  = cnt_q[i] + 4'd1;
      end
    end
  end

  logic scl_rise, scl_fall, sda_rise, sda_fall, start_cond, stop_cond;
  assign scl_rise   =  filt_q[0] & ~filt_prev_q[0];
  assign scl_fall   = ~filt_q[0] &  filt_prev_q[0];
  assign sda_rise   =  filt_q[1] & ~filt_prev_q[1];
  assign sda_fall   = ~filt_q[1] &  filt_prev_q[1];
  assign start_cond = sda_fall & filt_q[0];
  assign stop_cond  = sda_rise & filt_q[0];

  state_t     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] shift_q, shift_d;      // previously received bits of the byte
  logic [6:0] tx_shift_q, tx_shift_d; // bits still to send after the one on SDA
  logic [7:0] rx_data_q, rx_data_d, rx_byte;
  logic       sda_oe_q, sda_oe_d, scl_oe_q, scl_oe_d;
  logic       rx_valid_q, rx_valid_d, tx_req_q, tx_req_d;
  logic       start_q, start_d, stop_q, stop_d;
  logic       busy_q, busy_d, read_mode_q, read_mode_d;

  assign rx_byte = {shift_q, filt_q[1]};

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    tx_shift_d  = tx_shift_q;
    rx_data_d   = rx_data_q;
    sda_oe_d    = sda_oe_q;
    rx_valid_d  = 1'b0;
    tx_req_d    = 1'b0;
    start_d     = 1'b0;
    stop_d      = 1'b0;
    busy_d      = busy_q;
    read_mode_d = read_mode_q;

    if (stop_cond) begin
      stop_d   = 1'b1;
      state_d  = IDLE;
      busy_d   = 1'b0;
      sda_oe_d = 1'b0;
    end else if (start_cond && !sda_oe_q) begin
      // A falling SDA while we hold it low cannot be the controller's START.
      start_d   = 1'b1;
      state_d   = ADDR;
      bit_cnt_d = 3'd0;
      busy_d    = 1'b0;
      sda_oe_d  = 1'b0;
    end else begin
      unique case (state_q)
        ADDR, RX_BYTE: begin
          if (scl_rise) begin
            shift_d   = rx_byte[6:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (state_q == RX_BYTE) begin
                rx_data_d  = rx_byte;
                rx_valid_d = 1'b1;
                state_d    = RX_ACK;
              end else if (rx_byte[7:1] == TARGET_ADDRESS) begin
                busy_d      = 1'b1;
                read_mode_d = rx_byte[0];
                state_d     = ADDR_ACK;
              end else begin
                state_d = WAIT_STOP;
              end
            end
          end
        end
        ADDR_ACK, RX_ACK: begin
          // First falling edge starts the ACK low, the second one ends it.
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = 3'd0;
              if (state_q == ADDR_ACK && read_mode_q) begin
                tx_req_d = 1'b1;
                state_d  = TX_LOAD;
              end else begin
                state_d = RX_BYTE;
              end
            end
          end
        end
        TX_LOAD: begin
          if (tx_valid) begin
            tx_shift_d = tx_data[6:0];
            sda_oe_d   = ~tx_data[7];
            bit_cnt_d  = 3'd0;
            state_d    = TX_BYTE;
          end else if (!CLOCK_STRETCHING && scl_rise) begin
            // Underrun: the rising edge now sampling bit 7 sees a released line.
            tx_shift_d = 7'h7f;
            sda_oe_d   = 1'b0;
            bit_cnt_d  = 3'd0;
            state_d    = TX_BYTE;
          end
        end
        TX_BYTE: begin
          if (scl_fall) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              sda_oe_d = 1'b0;
              state_d  = TX_ACK;
            end else begin
              sda_oe_d   = ~tx_shift_q[6];
              tx_shift_d = {tx_shift_q[5:0], 1'b1};
            end
          end
        end
        TX_ACK: begin
          // NACK leaves on the rising edge, so a falling edge here means ACK.
          if (scl_rise && filt_q[1]) begin
            busy_d  = 1'b0;
            state_d = WAIT_STOP;
          end else if (scl_fall) begin
            tx_req_d = 1'b1;
            state_d  = TX_LOAD;
          end
        end
        IDLE, WAIT_STOP: ;
        default: state_d = IDLE;
      endcase
    end

    scl_oe_d = CLOCK_STRETCHING && (state_d == TX_LOAD);
  end

  // NOTE: sequential state is written with non-blocking assignments only.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      sync1_q     <= 2'b11;
      sync2_q     <= 2'b11;
      filt_q      <= 2'b11;
      filt_prev_q <= 2'b11;
      cnt_q[0]    <= 4'd0;
      cnt_q[1]    <= 4'd0;
      state_q     <= IDLE;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 7'd0;
      tx_shift_q  <= 7'd0;
      rx_data_q   <= 8'h00;
      sda_oe_q    <= 1'b0;
      scl_oe_q    <= 1'b0;
      rx_valid_q  <= 1'b0;
      tx_req_q    <= 1'b0;
      start_q     <= 1'b0;
      stop_q      <= 1'b0;
      busy_q      <= 1'b0;
      read_mode_q <= 1'b0;
    end else begin
      sync1_q     <= {sda, scl};
      sync2_q     <= sync1_q;
      filt_q      <= filt_d;
      filt_prev_q <= filt_q;
      cnt_q[0]    <= cnt_d[0];
      cnt_q[1]    <= cnt_d[1];
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      tx_shift_q  <= tx_shift_d;
      rx_data_q   <= rx_data_d;
      sda_oe_q    <= sda_oe_d;
      scl_oe_q    <= scl_oe_d;
      rx_valid_q  <= rx_valid_d;
      tx_req_q    <= tx_req_d;
      start_q     <= start_d;
      stop_q      <= stop_d;
      busy_q      <= busy_d;
      read_mode_q <= read_mode_d;
    end
  end

  assign scl            = scl_oe_q ? 1'b0 : 1'bz;
  assign sda            = sda_oe_q ? 1'b0 : 1'bz;
  assign rx_data        = rx_data_q;
  assign rx_valid       = rx_valid_q;
  assign tx_req         = tx_req_q;
  assign start_detected = start_q;
  assign stop_detected  = stop_q;
  assign busy           = busy_q;
  assign read_mode      = read_mode_q;

endmodule

// File: tb/tb_i2c_target.sv
`timescale 1ns/1ps
// Testbench for i2c_target. Two targets sit on two separate buses driven by
// one bit-banged controller: bus 0 holds a stretching target at 7'h50, bus 1
// a non-stretching target at 7'h30 whose read data never arrives.
module tb_i2c_target;

  localparam int Q = 25; // clk cycles per quarter SCL period

  logic clk_in = 1'b0;
  logic reset;
  logic m_scl_oe, m_sda_oe, sel;
  wire  scl0, sda0, scl1, sda1;

  pullup (scl0);
  pullup (sda0);
  pullup (scl1);
  pullup (sda1);
  assign scl0 = m_scl_oe ? 1'b0 : 1'bz;
  assign sda0 = m_sda_oe ? 1'b0 : 1'bz;
  assign scl1 = m_scl_oe ? 1'b0 : 1'bz;
  assign sda1 = m_sda_oe ? 1'b0 : 1'bz;

  always #5 clk_in = ~clk_in;

  logic [7:0] rx_data, tx_data;
  logic       rx_valid, tx_req, tx_valid, start_detected, stop_detected, busy, read_mode;
  logic [7:0] ns_rx_data;
  logic       ns_rx_valid, ns_tx_req, ns_start, ns_stop, ns_busy, ns_read_mode;
  logic [7:0] ns_tx_data  = 8'h00;
  logic       ns_tx_valid = 1'b0;

  i2c_target #(.TARGET_ADDRESS(7'h50), .FILTER_DEPTH(3), .CLOCK_STRETCHING(1'b1)) dut (
    .clk_in(clk_in), .reset(reset), .scl(scl0), .sda(sda0),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_req(tx_req),
    .tx_data(tx_data), .tx_valid(tx_valid),
    .start_detected(start_detected), .stop_detected(stop_detected),
    .busy(busy), .read_mode(read_mode)
  );

  i2c_target #(.TARGET_ADDRESS(7'h30), .FILTER_DEPTH(3), .CLOCK_STRETCHING(1'b0)) dut_ns (
    .clk_in(clk_in), .reset(reset), .scl(scl1), .sda(sda1),
    .rx_data(ns_rx_data), .rx_valid(ns_rx_valid), .tx_req(ns_tx_req),
    .tx_data(ns_tx_data), .tx_valid(ns_tx_valid),
    .start_detected(ns_start), .stop_detected(ns_stop),
    .busy(ns_busy), .read_mode(ns_read_mode)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Scoreboard queues.
  logic [7:0] rx_exp[$];
  logic [7:0] tx_q[$];
  logic [7:0] rd_exp[$];
  int tx_delay = 0;

  // Event monitors, sampled on the inactive clock edge.
  int rx_cnt = 0, start_cnt = 0, stop_cnt = 0, tx_req_cnt = 0;
  int dut_sda_low = 0, scl0_held = 0, scl1_held = 0;

  always @(negedge clk_in) begin
    if (!reset) begin
      start_cnt  += int'(start_detected);
      stop_cnt   += int'(stop_detected);
      tx_req_cnt += int'(tx_req);
      if (sda0 === 1'b0 && !m_sda_oe) dut_sda_low++;
      if (scl0 === 1'b0 && !m_scl_oe) scl0_held++;
      if (scl1 === 1'b0 && !m_scl_oe) scl1_held++;
      if (rx_valid) begin
        rx_cnt++;
        check("rx_expected", 32'(rx_exp.size() > 0), 1);
        if (rx_exp.size() > 0) check("rx_data", rx_data, rx_exp.pop_front());
      end
    end
  end

  // Read-data source for the stretching target.
  initial begin
    logic [7:0] d;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    forever begin
      @(negedge clk_in);
      if (!reset && tx_req) begin
        check("tx_expected", 32'(tx_q.size() > 0), 1);
        if (tx_q.size() > 0) begin
          d = tx_q.pop_front();
          repeat (tx_delay) @(negedge clk_in);
          tx_data  = d;
          tx_valid = 1'b1;
          @(negedge clk_in);
          tx_valid = 1'b0;
        end
      end
    end
  end

  // Bit-banged controller.
  task automatic wait_q();
    repeat (Q) @(negedge clk_in);
  endtask

  task automatic scl_release();
    int n = 0;
    m_scl_oe = 1'b0;
    while (!(scl0 === 1'b1 && scl1 === 1'b1) && n < 2000) begin
      @(negedge clk_in);
      n++;
    end
    if (n >= 2000) check("scl_release_timeout", n, 0);
  endtask

  task automatic i2c_start();
    m_sda_oe = 1'b1; wait_q();
    m_scl_oe = 1'b1; wait_q();
  endtask

  task automatic i2c_rep_start();
    m_sda_oe = 1'b0; wait_q();
    scl_release();   wait_q();
    m_sda_oe = 1'b1; wait_q();
    m_scl_oe = 1'b1; wait_q();
  endtask

  task automatic i2c_stop();
    m_sda_oe = 1'b1; wait_q();
    scl_release();   wait_q();
    m_sda_oe = 1'b0; wait_q();
  endtask

  task automatic write_bit(input logic b, input bit glitch);
    m_sda_oe = ~b; wait_q();
    scl_release(); wait_q();
    if (glitch) begin
      m_scl_oe = 1'b1;
      repeat (2) @(negedge clk_in);
      m_scl_oe = 1'b0;
    end
    wait_q();
    m_scl_oe = 1'b1; wait_q();
  endtask

  task automatic read_bit(output logic b);
    m_sda_oe = 1'b0; wait_q();
    scl_release();   wait_q();
    b = sel ? sda1 : sda0;
    wait_q();
    m_scl_oe = 1'b1; wait_q();
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) write_bit(d[i], 1'b0);
    read_bit(b);
    ack = ~b;
  endtask

  task automatic read_byte(output logic [7:0] d, input logic ack);
    logic b;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      read_bit(b);
      d = {d[6:0], b};
    end
    write_bit(~ack, 1'b0);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       ack;
    logic [7:0] d;
    int s0, p0, r0, t0, l0, h0;
    reset = 1'b1; m_scl_oe = 1'b0; m_sda_oe = 1'b0; sel = 1'b0;
    repeat (5) @(negedge clk_in);

    // Reset state.
    check("rst_busy", busy, 0);
    check("rst_read_mode", read_mode, 0);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_strobes", {rx_valid, tx_req, start_detected, stop_detected}, 4'b0000);
    check("rst_lines", {scl0, sda0}, 2'b11);
    reset = 1'b0;
    repeat (10) @(negedge clk_in);

    // Write to the target address.
    s0 = start_cnt; p0 = stop_cnt; r0 = rx_cnt;
    i2c_start();
    write_byte(8'hA0, ack); check("wr_addr_ack", ack, 1);
    rx_exp.push_back(8'h3C);
    write_byte(8'h3C, ack); check("wr_d0_ack", ack, 1);
    rx_exp.push_back(8'h5A);
    write_byte(8'h5A, ack); check("wr_d1_ack", ack, 1);
    check("wr_busy", busy, 1);
    check("wr_read_mode", read_mode, 0);
    i2c_stop(); wait_q();
    check("wr_rx_count", rx_cnt - r0, 2);
    check("wr_start_count", start_cnt - s0, 1);
    check("wr_stop_count", stop_cnt - p0, 1);
    check("wr_busy_after", busy, 0);

    // Address mismatch.
    p0 = stop_cnt; r0 = rx_cnt; l0 = dut_sda_low;
    i2c_start();
    write_byte(8'hA2, ack); check("mm_addr_nack", ack, 0);
    check("mm_busy", busy, 0);
    write_byte(8'h11, ack); check("mm_data_nack", ack, 0);
    i2c_stop(); wait_q();
    check("mm_sda_never_low", dut_sda_low - l0, 0);
    check("mm_rx_none", rx_cnt - r0, 0);
    check("mm_stop_count", stop_cnt - p0, 1);

    // Read with clock stretching: data arrives 200 cycles after tx_req.
    tx_delay = 200; t0 = tx_req_cnt; h0 = scl0_held;
    tx_q.push_back(8'hC3); rd_exp.push_back(8'hC3);
    i2c_start();
    write_byte(8'hA1, ack); check("rd_addr_ack", ack, 1);
    check("rd_read_mode", read_mode, 1);
    check("rd_busy", busy, 1);
    read_byte(d, 1'b0);
    check("rd_data", d, rd_exp.pop_front());
    check("rd_stretched", 32'(scl0_held - h0 >= 150), 1);
    check("rd_busy_after_nack", busy, 0);
    check("rd_tx_req_count", tx_req_cnt - t0, 1);
    i2c_stop(); wait_q();

    // Underrun on the non-stretching target: 8'hFF, SCL never held.
    sel = 1'b1; t0 = tx_req_cnt;
    rd_exp.push_back(8'hFF);
    i2c_start();
    write_byte(8'h61, ack); check("ur_addr_ack", ack, 1);
    check("ur_read_mode", ns_read_mode, 1);
    read_byte(d, 1'b0);
    check("ur_data", d, rd_exp.pop_front());
    check("ur_busy_after_nack", ns_busy, 0);
    i2c_stop(); wait_q();
    check("ur_scl_never_held", scl1_held, 0);
    check("ur_other_target_idle", tx_req_cnt - t0, 0);
    sel = 1'b0;

    // Repeated START: write then read; tx_valid in the same cycle as tx_req.
    tx_delay = 0; s0 = start_cnt; t0 = tx_req_cnt;
    rx_exp.push_back(8'h01);
    tx_q.push_back(8'h99); rd_exp.push_back(8'h99);
    i2c_start();
    write_byte(8'hA0, ack); check("rs_wr_ack", ack, 1);
    check("rs_read_mode_w", read_mode, 0);
    write_byte(8'h01, ack); check("rs_d_ack", ack, 1);
    i2c_rep_start();
    write_byte(8'hA1, ack); check("rs_rd_ack", ack, 1);
    check("rs_read_mode_r", read_mode, 1);
    read_byte(d, 1'b0);
    check("rs_data", d, rd_exp.pop_front());
    check("rs_start_count", start_cnt - s0, 2);
    check("rs_tx_req_count", tx_req_cnt - t0, 1);
    i2c_stop(); wait_q();

    // SCL glitch inside a bit must not shift an extra bit; then reset in ADDR_ACK.
    i2c_start();
    write_bit(1'b1, 1'b1);
    for (int i = 6; i >= 0; i--) write_bit(1'(i == 5), 1'b0);
    m_sda_oe = 1'b0; wait_q();
    check("gl_ack_driven", sda0, 0);
    reset = 1'b1;
    @(negedge clk_in);
    reset = 1'b0;
    check("rst_sda_released", sda0, 1);
    check("rst_busy_cleared", busy, 0);
    scl_release(); wait_q(); wait_q();
    m_scl_oe = 1'b1; wait_q();
    write_byte(8'hA0, ack); check("rst_idle_ignores", ack, 0);
    i2c_stop(); wait_q();

    check("sb_rx_drained", rx_exp.size(), 0);
    check("sb_tx_drained", tx_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2c_target.md
Name: i2c_target

Overview:
- 7-bit-address I2C target (slave). It is the responder at the far end of the bus from the controller-side SCL generator.
- Filters SCL/SDA, detects START/STOP, matches its address and ACKs.
- Delivers written bytes on a valid strobe. Sources read bytes through a request/valid handshake.
- Holds SCL low (clock stretching) while read data is not yet available.

Parameters:
- TARGET_ADDRESS, 7'h50, 7-bit bus address the block responds to.
- FILTER_DEPTH, 3, consecutive identical synchronized samples required before a filtered line changes (range 1..15).
- CLOCK_STRETCHING, 1, 1 = hold SCL low until tx_valid; 0 = never drive SCL, send 8'hFF on underrun.

Ports:
- clk_in  input  1  system clock; at least 20x the SCL rate.
- reset  input  1  synchronous, active-high reset.
- scl  inout  1  open-drain; driven 1'b0 or 1'bz only.
- sda  inout  1  open-drain; driven 1'b0 or 1'bz only.
- rx_data  output  8  last byte written by the controller.
- rx_valid  output  1  one-cycle strobe; rx_data is valid in that cycle.
- tx_req  output  1  one-cycle strobe requesting the next read byte.
- tx_data  input  8  read byte; captured when tx_valid=1.
- tx_valid  input  1  tx_data valid; honoured only while a request is pending.
- start_detected  output  1  one-cycle strobe on START or repeated START.
- stop_detected  output  1  one-cycle strobe on STOP.
- busy  output  1  high from an address match until STOP, repeated START or NACK-idle.
- read_mode  output  1  R/W bit of the current matched transaction.

Behaviour:
- Reset values:
  - scl and sda released (z).
  - All strobes 0; busy=0; read_mode=0; rx_data=8'h00.
  - Filtered lines=1; state=IDLE.
- Reset mid-transfer releases both lines in the next cycle.
- Input path:
  - 2-flop synchronizer per line, then a saturating counter filter.
  - The filtered value flips only after FILTER_DEPTH consecutive opposite samples.
  - Edges are derived from the filtered values only.
- START: filtered SDA falls while filtered SCL=1.
  - Accepted in any state, including mid-byte (repeated START).
  - Pulses start_detected, clears the bit counter, goes to ADDR, releases SDA.
  - If a START is seen while the target holds SDA low, the START has no effect and the ACK is kept.
- STOP: filtered SDA rises while filtered SCL=1.
  - Pulses stop_detected, goes to IDLE, busy=0, releases both lines.
- Bit sampling: on the filtered SCL rising edge. MSB first.
- Target SDA drive changes only on the filtered SCL falling edge.
- States:
  - IDLE: ignore the bus until START.
  - ADDR: shift 8 bits (7 address + R/W).
    - Match: go to ADDR_ACK, set busy and read_mode.
    - Mismatch: go to WAIT_STOP with the lines released.
  - ADDR_ACK: drive SDA=0 from the next falling edge through the following falling edge.
    - Write (read_mode=0): then go to RX_BYTE.
    - Read (read_mode=1): pulse tx_req at the ACK falling edge, then go to TX_LOAD.
  - RX_BYTE: shift 8 bits.
    - On the 8th rising edge: update rx_data and pulse rx_valid in the same cycle the 8th bit is shifted in.
    - Then go to RX_ACK.
  - RX_ACK: always ACK (SDA=0 for one SCL period), then return to RX_BYTE.
  - TX_LOAD: wait for tx_valid.
    - CLOCK_STRETCHING=1: hold scl=0 from entry until tx_valid; release SCL the cycle after capture.
    - CLOCK_STRETCHING=0: if no tx_valid by the next filtered SCL rising edge, send 8'hFF.
    - tx_valid that arrives early in the same cycle as tx_req is accepted.
  - TX_BYTE:
    - Drive bit 7 immediately after load; drive each following bit on a falling edge.
    - After the 8th falling edge, release SDA and go to TX_ACK.
  - TX_ACK: sample SDA on the rising edge.
    - 0 (ACK): pulse tx_req at the falling edge, go to TX_LOAD.
    - 1 (NACK): go to WAIT_STOP, busy=0.
  - WAIT_STOP: lines released; leave only on STOP (to IDLE) or START (to ADDR).
- Widths:
  - Bit counter is 3 bits and wraps 7 to 0 at the byte boundary.
  - The filter counter saturates; it never wraps.

Test Plan:
- Write to the target address: START, 0xA0, 0x3C, 0x5A, STOP → address ACK; rx_valid pulses twice with rx_data=8'h3C then 8'h5A; each data byte ACKed; stop_detected=1 once; busy falls.
- Address mismatch: START, 0xA2, 0x11, STOP → SDA never driven low; no rx_valid; busy stays 0; stop_detected still pulses.
- Read with stretching: START, 0xA1; bench holds tx_valid for 200 cycles after tx_req, then supplies 8'hC3 → scl held 0 for the wait; controller reads 8'hC3; controller NACK → WAIT_STOP, busy=0.
- Underrun with CLOCK_STRETCHING=0: read with tx_valid never asserted → scl never driven; read byte = 8'hFF.
- Repeated START: write 0xA0, 0x01, then START, 0xA1, read 8'h99 → start_detected twice; read_mode goes 0 then 1; tx_req pulses once before the NACK.
- Glitch and reset: a 2-cycle SCL low pulse with FILTER_DEPTH=3 → no bit shifted. Reset asserted during ADDR_ACK → SDA released next cycle; state IDLE.
